core_quant_lanes: RTL and testbench
===================================

Name: core_quant_lanes

Overview:
- Multi-lane, per-channel requantizer: each lane computes saturate(round((idata*scale[ch] + bias[ch]) >>> shift)) into ODATA_BIT signed.
- Sits between the accumulator array and the activation buffer. Next generation of the single-lane quantizer.
- Adds parallel lanes, a per-channel scale/bias table, selectable rounding and valid/ready backpressure.

Parameters:
- IDATA_BIT, 32, signed input/scale/bias width
- ODATA_BIT, 8, signed output width
- LANES, 4, parallel lanes per beat
- NUM_CH, 8, channel-table depth; must be a multiple of LANES
- SHIFT_BIT, $clog2(2*IDATA_BIT), shift-field width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_wr_en  in  1  table write strobe
- cfg_wr_addr  in  $clog2(NUM_CH)  channel index to write
- cfg_wr_scale  in  IDATA_BIT  scale for that channel
- cfg_wr_bias  in  IDATA_BIT  bias for that channel
- cfg_quant_shift  in  SHIFT_BIT  global right shift, held static while busy
- cfg_rnd_mode  in  1  0=floor (truncate), 1=round-half-up
- idata  in  LANES*IDATA_BIT  lane l in bits [l*IDATA_BIT +: IDATA_BIT]
- idata_valid  in  1  input beat valid
- idata_last  in  1  last beat of a row; qualified by valid
- idata_ready  out  1  input accepted when valid&ready
- odata  out  LANES*ODATA_BIT  quantized lanes, same packing
- odata_valid  out  1  output beat valid
- odata_last  out  1  last flag, delayed with its beat
- odata_ready  in  1  downstream accept

Behaviour:
- Reset (rst_n low, async):
  - odata, odata_valid, odata_last, internal stage valids and ch_base clear to 0.
  - Table scale/bias entries reset to 0.
- Pipeline:
  - Two register stages: S1 = multiply-add, S2 = shift/round/saturate, which drives the outputs.
  - Latency 2 cycles from accept to odata_valid when unstalled. Throughput 1 beat/cycle.
- Handshake (stall-all):
  - adv = ~odata_valid | odata_ready; idata_ready = adv. This is combinational from odata_ready, by design.
  - On adv: S1 <= input beat, with S1.valid = idata_valid; S2 <= S1.
  - When adv=0, all stages and outputs hold bit-stable.
- Channel mapping:
  - Lane l of an accepted beat uses table entry ch_base+l.
  - After each accepted beat, ch_base += LANES, wrapping to 0 at NUM_CH.
  - An accepted beat with idata_last=1 forces ch_base to 0 instead, regardless of position.
- Table writes:
  - A write is visible to beats accepted on the cycle after cfg_wr_en.
  - A write and an accept in the same cycle: the beat uses the old value.
  - Writes are allowed while stalled.
- Arithmetic, per lane:
  - p = $signed(idata_l)*$signed(scale) + $signed(bias), computed in 2*IDATA_BIT signed. No wrap at sum width; the overflow case is excluded by the config contract.
  - S2 computes s = p >>> cfg_quant_shift (arithmetic).
  - Mode 1 with shift>0: s = (p + (1 << (shift-1))) >>> shift, with the add done in 2*IDATA_BIT+1 bits.
  - Mode 1 with shift=0 equals mode 0.
- Saturation:
  - s > 2^(ODATA_BIT-1)-1 -> 0111..1.
  - s < -2^(ODATA_BIT-1) -> 1000..0.
  - Otherwise the low ODATA_BIT bits of s.
- Config timing:
  - cfg_quant_shift and cfg_rnd_mode are sampled in S2.
  - Changing either while beats are in flight is illegal; output in that case is unspecified but must not hang.
- Reset mid-operation: in-flight beats are discarded, ch_base returns to 0, and idata_ready=1 on the first cycle after release.

Optional Feature:
- Macro QUANT_SAT_CNT_EN.
- When defined, adds ports cfg_sat_clr (in, 1) and sat_cnt (out, 32).
  - On each S2 load, sat_cnt increases by the number of lanes that saturated, clamping at 2^32-1.
  - cfg_sat_clr=1 synchronously zeroes sat_cnt and takes priority over the increment.
  - sat_cnt resets to 0 on rst_n.
- When undefined, these ports and the logic are absent; all other behaviour is identical.

Test Plan:
- Floor mode: all channels scale=3, bias=5, shift=2, mode 0; lanes {10,-10,0,1} -> odata {8,-7,1,2} two cycles after accept.
- Round mode: same setup with mode 1; lanes {10,-10,0,1} -> {9,-6,1,2}.
- Saturation: scale=1, bias=0, shift=0; lanes {1000,-1000,127,-128} -> {127,-128,127,-128}. With QUANT_SAT_CNT_EN, sat_cnt=2, then 0 after cfg_sat_clr.
- Channel wrap/last:
  - Set scale[ch]=ch+1, bias=0, shift=0; send three beats of all-ones lanes -> {1,2,3,4}, {5,6,7,8}, {1,2,3,4}.
  - Then a beat with idata_last on beat 1 -> next beat restarts at {1,2,3,4}, and odata_last asserts on the matching output only.
- Backpressure: stream 6 beats while dropping odata_ready for 3 cycles mid-stream -> idata_ready=0 and odata stable during the stall; all 6 beats emerge in order with no loss or duplication.
- Reset mid-stream: pulse rst_n low with 2 beats in flight -> odata_valid=0 immediately (async); after release, the first accepted beat uses channel 0.

Source files
------------

// File: rtl/core_quant_lanes.sv
`default_nettype none
// ==========================================================================
// core_quant_lanes : multi-lane per-channel requantizer, 2-stage stall-all
// Optional QUANT_SAT_CNT_EN adds a saturation counter.   Rev 1.0
// ==========================================================================
module core_quant_lanes #(
  parameter int IDATA_BIT = 32,
  parameter int ODATA_BIT = 8,
  parameter int LANES     = 4,
  parameter int NUM_CH    = 8,
  parameter int SHIFT_BIT = $clog2(2*IDATA_BIT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_wr_en,
  input  logic [$clog2(NUM_CH)-1:0]    cfg_wr_addr,
  input  logic [IDATA_BIT-1:0]         cfg_wr_scale,
  input  logic [IDATA_BIT-1:0]         cfg_wr_bias,
  input  logic [SHIFT_BIT-1:0]         cfg_quant_shift,
  input  logic                         cfg_rnd_mode,
  input  logic [LANES*IDATA_BIT-1:0]   idata,
  input  logic                         idata_valid,
  input  logic                         idata_last,
  output logic                         idata_ready,
  output logic [LANES*ODATA_BIT-1:0]   odata,
  output logic                         odata_valid,
  output logic                         odata_last,
`ifdef QUANT_SAT_CNT_EN
  input  logic                         cfg_sat_clr,
  output logic [31:0]                  sat_cnt,
`endif
  input  logic                         odata_ready
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int PW   = 2*IDATA_BIT;
  localparam int SW   = PW + 1;
  localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) <<< (ODATA_BIT-1)) - SW'(1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  logic                        adv;
  logic                        accept;
  logic signed [IDATA_BIT-1:0] r_scale [NUM_CH];
  logic signed [IDATA_BIT-1:0] r_bias  [NUM_CH];
  logic [CH_W-1:0]             r_ch_base;
  logic                        r_s1_valid;
  logic                        r_s1_last;
  logic signed [PW-1:0]        r_s1_p [LANES];
  logic signed [PW-1:0]        w_p    [LANES];
  logic [LANES*ODATA_BIT-1:0]  w_q;
`ifdef QUANT_SAT_CNT_EN
  logic [LANES-1:0]            w_sat;
`endif

  // Stall-all: every stage advances together, so ready is just "output can move".
  assign adv         = ~odata_valid | odata_ready;
  assign idata_ready = adv;
  assign accept      = idata_valid & adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_scale[i] <= '0;
        r_bias[i]  <= '0;
      end
    end else if (cfg_wr_en) begin
      r_scale[cfg_wr_addr] <= cfg_wr_scale;
      r_bias[cfg_wr_addr]  <= cfg_wr_bias;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_base <= '0;
    end else if (accept) begin
      if (idata_last || (int'(r_ch_base) + LANES >= NUM_CH))
        r_ch_base <= '0;
      else
        r_ch_base <= r_ch_base + CH_W'(LANES);
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [CH_W-1:0]             w_ch;
    logic signed [IDATA_BIT-1:0] w_in;
    logic signed [SW-1:0]        w_pe;
    logic signed [SW-1:0]        w_rnd;
    logic signed [SW-1:0]        w_s;
    logic                        w_hi;
    logic                        w_lo;

    assign w_ch   = r_ch_base + CH_W'(l);
    assign w_in   = idata[l*IDATA_BIT +: IDATA_BIT];
    assign w_p[l] = PW'(w_in) * PW'(r_scale[w_ch]) + PW'(r_bias[w_ch]);

    // One extra bit so the half-LSB add cannot wrap.
    assign w_pe  = SW'(r_s1_p[l]);
    assign w_rnd = (cfg_rnd_mode && (cfg_quant_shift != '0))
                 ? (SW'(1) <<< (cfg_quant_shift - SHIFT_BIT'(1))) : '0;
    assign w_s   = (w_pe + w_rnd) >>> cfg_quant_shift;
    assign w_hi  = w_s > SAT_MAX;
    assign w_lo  = w_s < SAT_MIN;
    assign w_q[l*ODATA_BIT +: ODATA_BIT] = w_hi ? SAT_MAX[ODATA_BIT-1:0] :
                                           w_lo ? SAT_MIN[ODATA_BIT-1:0] :
                                                  w_s[ODATA_BIT-1:0];
`ifdef QUANT_SAT_CNT_EN
    assign w_sat[l] = w_hi | w_lo;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      for (int i = 0; i < LANES; i++) r_s1_p[i] <= '0;
    end else if (adv) begin
      r_s1_valid <= idata_valid;
      r_s1_last  <= idata_valid & idata_last;
      for (int i = 0; i < LANES; i++) r_s1_p[i] <= w_p[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      odata       <= '0;
      odata_valid <= 1'b0;
      odata_last  <= 1'b0;
    end else if (adv) begin
      odata       <= w_q;
      odata_valid <= r_s1_valid;
      odata_last  <= r_s1_last;
    end
  end

`ifdef QUANT_SAT_CNT_EN
  localparam int NS_W = $clog2(LANES+1);

  logic [NS_W-1:0] w_nsat;
  logic [32:0]     w_sum;
  logic [31:0]     r_sat_cnt;

  always_comb begin
    w_nsat = '0;
    for (int i = 0; i < LANES; i++) w_nsat = w_nsat + NS_W'(w_sat[i]);
  end

  assign w_sum = {1'b0, r_sat_cnt} + 33'(w_nsat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_sat_cnt <= '0;
    else if (cfg_sat_clr)
      r_sat_cnt <= '0;
    else if (adv && r_s1_valid)
      r_sat_cnt <= w_sum[32] ? '1 : w_sum[31:0];
  end

  assign sat_cnt = r_sat_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_quant_lanes.sv
`default_nettype none
// ==========================================================================
// tb_core_quant_lanes : directed scoreboard bench for core_quant_lanes
// Rev 1.0
// ==========================================================================
module tb_core_quant_lanes;

  localparam int IB = 32;
  localparam int OB = 8;
  localparam int L  = 4;
  localparam int NC = 8;
  localparam int SB = 6;

  logic          clk;
  logic          rst_n;
  logic          cfg_wr_en;
  logic [2:0]    cfg_wr_addr;
  logic [IB-1:0] cfg_wr_scale;
  logic [IB-1:0] cfg_wr_bias;
  logic [SB-1:0] cfg_quant_shift;
  logic          cfg_rnd_mode;
  logic [L*IB-1:0] idata;
  logic          idata_valid;
  logic          idata_last;
  logic          idata_ready;
  logic [L*OB-1:0] odata;
  logic          odata_valid;
  logic          odata_last;
  logic          odata_ready;
`ifdef QUANT_SAT_CNT_EN
  logic          cfg_sat_clr;
  logic [31:0]   sat_cnt;
`endif

  core_quant_lanes dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_scale(cfg_wr_scale), .cfg_wr_bias(cfg_wr_bias),
    .cfg_quant_shift(cfg_quant_shift), .cfg_rnd_mode(cfg_rnd_mode),
    .idata(idata), .idata_valid(idata_valid), .idata_last(idata_last),
    .idata_ready(idata_ready),
    .odata(odata), .odata_valid(odata_valid), .odata_last(odata_last),
`ifdef QUANT_SAT_CNT_EN
    .cfg_sat_clr(cfg_sat_clr), .sat_cnt(sat_cnt),
`endif
    .odata_ready(odata_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            ntests = 0;
  int            nfail  = 0;
  logic [32:0]   q[$];
  longint        tscale [NC];
  longint        tbias  [NC];
  int            mbase  = 0;
  logic          prev_stall = 1'b0;
  logic [L*OB-1:0] prev_odata = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OB-1:0] qm(input longint x, input longint sc, input longint bi,
                                       input int sh, input bit rnd);
    longint p;
    longint s;
    p = x*sc + bi;
    if (rnd && sh > 0) s = (p + (longint'(1) << (sh-1))) >>> sh;
    else               s = p >>> sh;
    if (s > 127)  return 8'h7f;
    if (s < -128) return 8'h80;
    return s[OB-1:0];
  endfunction

  task automatic wr(input int a, input int sc, input int bi);
    cfg_wr_en = 1'b1; cfg_wr_addr = 3'(a); cfg_wr_scale = sc; cfg_wr_bias = bi;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
    tscale[a] = sc; tbias[a] = bi;
  endtask

  // Drive one beat until accepted; the model's expectation is pushed on accept.
  task automatic send(input int v0, input int v1, input int v2, input int v3, input bit last);
    int   v[L];
    logic acc;
    logic [L*OB-1:0] e;
    v = '{v0, v1, v2, v3};
    for (int l = 0; l < L; l++) idata[l*IB +: IB] = v[l];
    idata_valid = 1'b1; idata_last = last;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = idata_ready;
      if (acc) begin
        for (int l = 0; l < L; l++)
          e[l*OB +: OB] = qm(v[l], tscale[mbase+l], tbias[mbase+l],
                             int'(cfg_quant_shift), cfg_rnd_mode);
        q.push_back({last, e});
        mbase = (last || mbase + L >= NC) ? 0 : mbase + L;
      end
      @(posedge clk); #1;
    end
    idata_valid = 1'b0; idata_last = 1'b0;
    check("accept_timeout", 64'(acc), 64'd1);
  endtask

  // Beat into an idle pipe: invisible one cycle later, fixed value two cycles later.
  task automatic lit_beat(input int v0, input int v1, input int v2, input int v3,
                          input bit last, input logic [L*OB-1:0] lit);
    send(v0, v1, v2, v3, last);
    check("latency_1", 64'(odata_valid), 64'd0);
    @(posedge clk); #1;
    check("latency_2", 64'(odata_valid), 64'd1);
    check("literal_data", 64'(odata), 64'(lit));
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    check("drain", 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && odata_valid && odata_ready) begin
      logic [32:0] ex;
      ntests++;
      assert (q.size() > 0) else begin
        nfail++;
        $error("FAIL spurious_out: observed %0h expected none", odata);
      end
      if (q.size() > 0) begin
        ex = q.pop_front();
        check("out_data", 64'(odata), 64'(ex[31:0]));
        check("out_last", 64'(odata_last), 64'(ex[32]));
      end
    end
    if (rst_n && odata_valid && !odata_ready)
      check("stall_ready", 64'(idata_ready), 64'd0);
    if (rst_n && prev_stall)
      check("stall_hold", 64'(odata), 64'(prev_odata));
    prev_stall = rst_n && odata_valid && !odata_ready;
    prev_odata = odata;
  end

  initial begin
    rst_n = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_scale = '0; cfg_wr_bias = '0;
    cfg_quant_shift = '0; cfg_rnd_mode = 1'b0; idata = '0; idata_valid = 1'b0;
    idata_last = 1'b0; odata_ready = 1'b1;
`ifdef QUANT_SAT_CNT_EN
    cfg_sat_clr = 1'b0;
`endif
    for (int i = 0; i < NC; i++) begin tscale[i] = 0; tbias[i] = 0; end
    repeat (3) @(posedge clk); #1;
    check("rst_valid", 64'(odata_valid), 64'd0);
    check("rst_data",  64'(odata), 64'd0);
    check("rst_last",  64'(odata_last), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 64'(idata_ready), 64'd1);

    // Floor then round-half-up
    for (int i = 0; i < NC; i++) wr(i, 3, 5);
    cfg_quant_shift = 6'd2; cfg_rnd_mode = 1'b0;
    lit_beat(10, -10, 0, 1, 1'b0, 32'h0201F908);
    drain();
    cfg_rnd_mode = 1'b1;
    lit_beat(10, -10, 0, 1, 1'b0, 32'h0201FA09);
    drain();

    // Saturation (last=1 also realigns the channel base to 0)
    for (int i = 0; i < NC; i++) wr(i, 1, 0);
    cfg_quant_shift = 6'd0; cfg_rnd_mode = 1'b0;
    lit_beat(1000, -1000, 127, -128, 1'b1, 32'h807F807F);
`ifdef QUANT_SAT_CNT_EN
    check("sat_cnt", 64'(sat_cnt), 64'd2);
    cfg_sat_clr = 1'b1;
    @(posedge clk); #1;
    cfg_sat_clr = 1'b0;
    check("sat_clr", 64'(sat_cnt), 64'd0);
`endif
    drain();

    // Channel wrap and last restart
    for (int i = 0; i < NC; i++) wr(i, i+1, 0);
    lit_beat(1, 1, 1, 1, 1'b0, 32'h04030201);
    send(1, 1, 1, 1, 1'b0);
    send(1, 1, 1, 1, 1'b0);
    send(1, 1, 1, 1, 1'b0);
    send(1, 1, 1, 1, 1'b1);
    send(1, 1, 1, 1, 1'b0);
    drain();

    // Table write colliding with an accept: beat sees the old entry
    cfg_wr_en = 1'b1; cfg_wr_addr = 3'(mbase); cfg_wr_scale = 100; cfg_wr_bias = 0;
    begin
      int a;
      a = mbase;
      send(1, 1, 1, 1, 1'b0);
      cfg_wr_en = 1'b0;
      tscale[a] = 100; tbias[a] = 0;
    end
    send(1, 1, 1, 1, 1'b0);
    send(1, 1, 1, 1, 1'b0);
    drain();
    for (int i = 0; i < NC; i++) wr(i, i+1, 0);

    // Backpressure mid-stream
    fork
      for (int b = 0; b < 6; b++) send(b, -b-1, 2*b+1, 30-b, 1'b0);
      begin
        repeat (2) @(posedge clk); #1;
        odata_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        odata_ready = 1'b1;
      end
    join
    drain();

    // Async reset with two beats in flight
    send(2, 2, 2, 2, 1'b1);
    send(2, 2, 2, 2, 1'b0);
    drain();
    send(1, 1, 1, 1, 1'b0);
    send(1, 1, 1, 1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(odata_valid), 64'd0);
    q.delete();
    mbase = 0;
    for (int i = 0; i < NC; i++) begin tscale[i] = 0; tbias[i] = 0; end
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    check("ready_after_rst", 64'(idata_ready), 64'd1);
    for (int i = 0; i < NC; i++) wr(i, i+1, 0);
    lit_beat(1, 1, 1, 1, 1'b0, 32'h04030201);
    drain();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
